// File: rtl/full_adder.sv
// Carry-lookahead adder cell with propagate/generate outputs and a registered copy.
// Ports:
//   clk, rst            : clock and async active-high reset (registered copy only)
//   a, b, c_in          : operands and carry in
//   s, c_out, p, g      : combinational sum, carry out, group propagate/generate
//   s_q, c_out_q, p_q, g_q : the same values, registered one cycle later
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             p,
    output logic             g,
    output logic [WIDTH-1:0] s_q,
    output logic             c_out_q,
    output logic             p_q,
    output logic             g_q
);

    // Operands are padded up to whole 4-bit lookahead groups.
    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] pv;
    logic [PW-1:0] gv;
    logic [WIDTH:0] c;
    logic [WIDTH:0] cz;

    // Padded bits have p=0, g=0, so nothing leaks past bit WIDTH-1.
    assign pv = PW'(a ^ b);
    assign gv = PW'(a & b);

    // Lookahead inside each 4-bit group; group carries ripple between groups.
    function automatic logic [WIDTH:0] chain(
        input logic [PW-1:0] pp,
        input logic [PW-1:0] gg,
        input logic          ci
    );
        logic [PW:0] cc;
        logic [3:0]  pk;
        logic [3:0]  gk;
        cc    = '0;
        cc[0] = ci;
        for (int k = 0; k < NG; k++) begin
            pk = pp[4*k +: 4];
            gk = gg[4*k +: 4];
            cc[4*k+1] = gk[0]
                      | (pk[0] & cc[4*k]);
            cc[4*k+2] = gk[1]
                      | (pk[1] & gk[0])
                      | ((&pk[1:0]) & cc[4*k]);
            cc[4*k+3] = gk[2]
                      | (pk[2] & gk[1])
                      | ((&pk[2:1]) & gk[0])
                      | ((&pk[2:0]) & cc[4*k]);
            cc[4*k+4] = gk[3]
                      | (pk[3] & gk[2])
                      | ((&pk[3:2]) & gk[1])
                      | ((&pk[3:1]) & gk[0])
                      | ((&pk) & cc[4*k]);
        end
        return cc[WIDTH:0];
    endfunction

    assign c  = chain(pv, gv, c_in);
    // Group generate is the carry out with the carry in forced low.
    assign cz = chain(pv, gv, 1'b0);

    assign s     = pv[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign c_out = c[WIDTH];
    assign p     = &pv[WIDTH-1:0];
    assign g     = cz[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            s_q     <= s;
            c_out_q <= c_out;
            p_q     <= p;
            g_q     <= g;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at widths 1, 8 and 13.
// Expected values come from plain integer arithmetic on the operands.
module tb_full_adder;

    logic clk;
    logic rst;

    logic a1, b1, ci1;
    logic s1, co1, p1, g1;
    logic s1_q, co1_q, p1_q, g1_q;

    logic [7:0] a8, b8;
    logic       ci8;
    logic [7:0] s8;
    logic       co8, p8, g8;
    logic [7:0] s8_q;
    logic       co8_q, p8_q, g8_q;

    logic [12:0] a13, b13;
    logic        ci13;
    logic [12:0] s13;
    logic        co13, p13, g13;
    logic [12:0] s13_q;
    logic        co13_q, p13_q, g13_q;

    int vectors;
    int miscompares;

    full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1),
        .s(s1), .c_out(co1), .p(p1), .g(g1),
        .s_q(s1_q), .c_out_q(co1_q), .p_q(p1_q), .g_q(g1_q)
    );

    full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8),
        .s(s8), .c_out(co8), .p(p8), .g(g8),
        .s_q(s8_q), .c_out_q(co8_q), .p_q(p8_q), .g_q(g8_q)
    );

    full_adder #(.WIDTH(13)) u13 (
        .clk(clk), .rst(rst), .a(a13), .b(b13), .c_in(ci13),
        .s(s13), .c_out(co13), .p(p13), .g(g13),
        .s_q(s13_q), .c_out_q(co13_q), .p_q(p13_q), .g_q(g13_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Reference: the whole-word sum a+b+ci, split into sum and carry.
    task automatic cmp(input string tag, input int w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ci,
                       input logic [63:0] so, input logic [63:0] coo,
                       input logic [63:0] po, input logic [63:0] go);
        logic [63:0] mask, sum, es, eco, ep, eg;
        mask = (64'd1 << w) - 64'd1;
        sum  = a + b + ci;
        es   = sum & mask;
        eco  = (sum >> w) & 64'd1;
        ep   = {63'd0, ((a ^ b) & mask) == mask};
        eg   = ((a + b) >> w) & 64'd1;
        chk({tag, ".s"}, so, es);
        chk({tag, ".c_out"}, coo, eco);
        chk({tag, ".p"}, po, ep);
        chk({tag, ".g"}, go, eg);
        chk({tag, ".ident"}, coo, go | (po & ci));
    endtask

    task automatic chk_q_zero(input string tag);
        chk({tag, ".s1_q"}, {63'd0, s1_q}, 64'd0);
        chk({tag, ".c1_q"}, {63'd0, co1_q}, 64'd0);
        chk({tag, ".p1_q"}, {63'd0, p1_q}, 64'd0);
        chk({tag, ".g1_q"}, {63'd0, g1_q}, 64'd0);
        chk({tag, ".s8_q"}, {56'd0, s8_q}, 64'd0);
        chk({tag, ".c8_q"}, {63'd0, co8_q}, 64'd0);
        chk({tag, ".s13_q"}, {51'd0, s13_q}, 64'd0);
        chk({tag, ".g13_q"}, {63'd0, g13_q}, 64'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        a1 = 0; b1 = 0; ci1 = 0;
        a8 = 0; b8 = 0; ci8 = 0;
        a13 = 0; b13 = 0; ci13 = 0;
        #1 rst = 1'b1;
        #1 chk_q_zero("reset");

        // WIDTH=1 exhaustive sweep of {c_in,a,b}
        for (int v = 0; v < 8; v++) begin
            {ci1, a1, b1} = 3'(v);
            #100;
            vectors++;
            cmp($sformatf("w1.v%0d", v), 1, a1, b1, ci1, s1, co1, p1, g1);
        end
        chk("w1.111.s", {63'd0, s1}, 64'd1);
        chk("w1.111.c", {63'd0, co1}, 64'd1);
        chk("w1.111.g", {63'd0, g1}, 64'd1);
        chk_q_zero("rst_hold");

        // WIDTH=8 directed boundaries
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; #1; vectors++;
        cmp("w8.ff_c1", 8, a8, b8, ci8, s8, co8, p8, g8);
        chk("w8.ff_c1.s", {56'd0, s8}, 64'h00);
        ci8 = 1'b0; #1; vectors++;
        cmp("w8.ff_c0", 8, a8, b8, ci8, s8, co8, p8, g8);
        chk("w8.ff_c0.s", {56'd0, s8}, 64'hFF);
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; #1; vectors++;
        cmp("w8.80", 8, a8, b8, ci8, s8, co8, p8, g8);
        chk("w8.80.g", {63'd0, g8}, 64'd1);
        a8 = 8'h3C; b8 = 8'h5A; ci8 = 1'b1; #1; vectors++;
        cmp("w8.3c5a", 8, a8, b8, ci8, s8, co8, p8, g8);
        chk("w8.3c5a.s", {56'd0, s8}, 64'h97);
        a13 = 13'h1FFF; b13 = 13'h0; ci13 = 1'b1; #1; vectors++;
        cmp("w13.full", 13, a13, b13, ci13, s13, co13, p13, g13);

        // Random vectors: combinational and one-cycle registered copy
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom); ci13 = 1'($urandom);
            if (i % 7 == 0) b13 = ~a13;
            if (i % 11 == 0) b8 = ~a8;
            #1;
            vectors++;
            cmp("rnd8", 8, a8, b8, ci8, s8, co8, p8, g8);
            cmp("rnd13", 13, a13, b13, ci13, s13, co13, p13, g13);
            @(posedge clk);
            #1;
            cmp("rnd8_q", 8, a8, b8, ci8, s8_q, co8_q, p8_q, g8_q);
            cmp("rnd13_q", 13, a13, b13, ci13, s13_q, co13_q, p13_q, g13_q);
        end

        // Registered path and asynchronous reset
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        chk("reg.s_q", {63'd0, s1_q}, 64'd0);
        chk("reg.c_q", {63'd0, co1_q}, 64'd1);
        chk("reg.g_q", {63'd0, g1_q}, 64'd1);
        chk("reg.p_q", {63'd0, p1_q}, 64'd0);
        #4 rst = 1'b1;
        #1 chk_q_zero("async_rst");
        chk("rst.comb.c", {63'd0, co1}, 64'd1);
        chk("rst.comb.s", {63'd0, s1}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b1; ci1 = 1'b0;
        #1 chk_q_zero("post_rst");
        @(posedge clk);
        #1;
        vectors++;
        chk("load.s_q", {63'd0, s1_q}, 64'd1);
        chk("load.p_q", {63'd0, p1_q}, 64'd1);
        chk("load.c_q", {63'd0, co1_q}, 64'd0);
        chk("load.g_q", {63'd0, g1_q}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
